// File: rtl/regwrite_arbiter_pkg.sv
// Shared writeback types: machine word, register number and a tagged result.
`include "definitions.svh"

package regwrite_arbiter_pkg;
  localparam int WORD_W   = 32;
  localparam int REGNUM_W = $clog2(`REGISTER_COUNT);

  typedef logic [WORD_W-1:0]   word;
  typedef logic [REGNUM_W-1:0] regnum;

  typedef struct packed {
    regnum dest;
    word   data;
  } wb_result;

  // x0 is hardwired zero, so results aimed at it are consumed silently.
  function automatic logic is_writable(input regnum r);
    return r != '0;
  endfunction
endpackage

// File: rtl/definitions.svh
// Global machine definitions shared by the writeback datapath.
`ifndef DEFINITIONS_SVH
`define DEFINITIONS_SVH
`define REGISTER_COUNT 32
`endif

// File: rtl/result_fifo.sv
// In-order buffer for load results waiting for a free register-set write slot.
module result_fifo
  import regwrite_arbiter_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic     clk,
  input  logic     res_n,
  input  logic     push,
  input  wb_result push_data,
  input  logic     pop,
  output wb_result head,
  output logic     full,
  output logic     empty
);
  localparam int PTR_W = $clog2(Depth);
  typedef logic [PTR_W:0] ptr_t;

  wb_result mem [Depth];
  ptr_t     wr_ptr;
  ptr_t     rd_ptr;
  logic     do_push;
  logic     do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign empty   = wr_ptr == rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
      if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
  end
endmodule

// File: rtl/regwrite_arbiter.sv
// Single-port register writeback arbiter: ALU results win, loads are buffered,
// and a busy scoreboard tracks registers with uncommitted writes.
`include "definitions.svh"

module regwrite_arbiter
  import regwrite_arbiter_pkg::*;
#(
  parameter int RegisterCount = `REGISTER_COUNT,
  parameter int MemFifoDepth  = 2
) (
  input  logic  clk,
  input  logic  res_n,
  input  logic  alu_valid,
  input  regnum alu_reg,
  input  word   alu_data,
  input  logic  mem_valid,
  output logic  mem_ready,
  input  regnum mem_reg,
  input  word   mem_data,
  output word   write,
  output regnum write_reg,
  output logic  write_enable,
  input  logic  issue_valid,
  input  regnum issue_reg,
  input  regnum q0_reg,
  input  regnum q1_reg,
  output logic  q0_busy,
  output logic  q1_busy,
  output logic  stray_write
);
  wb_result                 fifo_head;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_pop;
  wb_result                 sel_p0;
  logic                     vld_p0;
  logic [RegisterCount-1:0] busy;
  logic [RegisterCount-1:0] busy_nxt;

  result_fifo #(
    .Depth(MemFifoDepth)
  ) u_result_fifo (
    .clk      (clk),
    .res_n    (res_n),
    .push     (mem_valid),
    .push_data({mem_reg, mem_data}),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign mem_ready = !fifo_full;

  // Stage p0: pick the winning result for this cycle's write slot.
  always_comb begin
    fifo_pop = !alu_valid && !fifo_empty;
    vld_p0   = alu_valid || !fifo_empty;
    sel_p0   = alu_valid ? wb_result'{dest: alu_reg, data: alu_data} : fifo_head;
  end

  // Stage p1: registered register-set write port.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      write_enable <= 1'b0;
      write        <= '0;
      write_reg    <= '0;
    end else begin
      write_enable <= vld_p0 && is_writable(sel_p0.dest);
      if (vld_p0 && is_writable(sel_p0.dest)) begin
        write     <= sel_p0.data;
        write_reg <= sel_p0.dest;
      end
    end
  end

  // Clear on commit first so a same-edge issue of that register wins.
  always_comb begin
    busy_nxt = busy;
    if (write_enable)
      busy_nxt[write_reg] = 1'b0;
    if (issue_valid)
      busy_nxt[issue_reg] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      busy        <= '0;
      stray_write <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (write_enable && !busy[write_reg])
        stray_write <= 1'b1;
    end
  end

  assign q0_busy = busy[q0_reg];
  assign q1_busy = busy[q1_reg];
endmodule

// File: tb/tb_regwrite_arbiter.sv
// Bench for regwrite_arbiter: directed vector table, hand-built reset sequence
// and randomized traffic compared with a queue-based reference model.
module tb_regwrite_arbiter;
  import regwrite_arbiter_pkg::*;

  localparam int DEPTH = 2;

  logic  clk = 1'b0;
  logic  res_n = 1'b1;
  logic  alu_valid, mem_valid, issue_valid;
  regnum alu_reg, mem_reg, issue_reg, q0_reg, q1_reg;
  word   alu_data, mem_data;
  logic  mem_ready, write_enable, q0_busy, q1_busy, stray_write;
  word   write;
  regnum write_reg;

  int nvec = 0;
  int nerr = 0;

  regwrite_arbiter #(
    .RegisterCount(32),
    .MemFifoDepth (DEPTH)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .alu_valid   (alu_valid),
    .alu_reg     (alu_reg),
    .alu_data    (alu_data),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_reg     (mem_reg),
    .mem_data    (mem_data),
    .write       (write),
    .write_reg   (write_reg),
    .write_enable(write_enable),
    .issue_valid (issue_valid),
    .issue_reg   (issue_reg),
    .q0_reg      (q0_reg),
    .q1_reg      (q1_reg),
    .q0_busy     (q0_busy),
    .q1_busy     (q1_busy),
    .stray_write (stray_write)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: buffered loads as a queue, busy flags as a bit array.
  wb_result mq[$];
  bit       mbusy[32];
  bit       m_we;
  regnum    m_wr;
  word      m_w;
  bit       m_stray;

  task automatic model_reset();
    mq.delete();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    m_we = 1'b0; m_wr = '0; m_w = '0; m_stray = 1'b0;
  endtask

  task automatic model_step();
    bit       accept;
    wb_result e;
    accept = mem_valid && (mq.size() < DEPTH);
    if (m_we) begin
      if (!mbusy[m_wr]) m_stray = 1'b1;
      mbusy[m_wr] = 1'b0;
    end
    if (issue_valid && issue_reg != 0) mbusy[issue_reg] = 1'b1;
    if (alu_valid) begin
      m_we = (alu_reg != 0);
      if (m_we) begin m_wr = alu_reg; m_w = alu_data; end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = (e.dest != 0);
      if (m_we) begin m_wr = e.dest; m_w = e.data; end
    end else begin
      m_we = 1'b0;
    end
    if (accept) mq.push_back(wb_result'{dest: mem_reg, data: mem_data});
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_reg = '0; alu_data = '0;
    mem_valid = 0; mem_reg = '0; mem_data = '0;
    issue_valid = 0; issue_reg = '0; q0_reg = '0; q1_reg = '0;
  endtask

  task automatic do_reset();
    res_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic cycle(input string tag);
    @(negedge clk);
    chk({tag, ".mem_ready"}, mem_ready, mq.size() < DEPTH);
    chk({tag, ".q0_busy"}, q0_busy, (q0_reg != 0) && mbusy[q0_reg]);
    chk({tag, ".q1_busy"}, q1_busy, (q1_reg != 0) && mbusy[q1_reg]);
    @(posedge clk);
    model_step();
    #1;
    chk({tag, ".write_enable"}, write_enable, m_we);
    chk({tag, ".write_reg"}, write_reg, m_wr);
    chk({tag, ".write"}, write, m_w);
    chk({tag, ".stray_write"}, stray_write, m_stray);
  endtask

  typedef struct {
    logic av; regnum ar; word ad;
    logic mv; regnum mr; word md;
    logic iv; regnum ir; regnum q0;
    logic e_q0b; logic e_rdy;
    logic e_we; regnum e_wr; word e_w; logic e_stray;
  } vec_t;

  function automatic vec_t mk(logic av, regnum ar, word ad, logic mv, regnum mr, word md,
                              logic iv, regnum ir, regnum q0, logic eq0b, logic erdy,
                              logic ewe, regnum ewr, word ew, logic estray);
    vec_t v;
    v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
    v.iv = iv; v.ir = ir; v.q0 = q0; v.e_q0b = eq0b; v.e_rdy = erdy;
    v.e_we = ewe; v.e_wr = ewr; v.e_w = ew; v.e_stray = estray;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    idle_inputs();
    #2 res_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.write_enable", write_enable, 1'b0);
    chk("rst.write", write, '0);
    chk("rst.write_reg", write_reg, '0);
    chk("rst.stray_write", stray_write, 1'b0);
    @(negedge clk);
    res_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst.mem_ready", mem_ready, 1'b1);

    //                av ar  ad       mv mr md      iv ir q0  q0b rdy we wr wd       stray
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   1, 5, 5,  0, 1,  0, 0, 'h0,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 5,  1, 1,  0, 0, 'h0,    0));
    tbl.push_back(mk(1, 5, 'h1234,  0, 0, 'h0,   0, 0, 5,  1, 1,  1, 5, 'h1234, 0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 5,  1, 1,  0, 5, 'h1234, 0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 5,  0, 1,  0, 5, 'h1234, 0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   1, 7, 7,  0, 1,  0, 5, 'h1234, 0));
    tbl.push_back(mk(1, 0, 'hFFFF,  1, 7, 'hA,   1, 8, 7,  1, 1,  0, 5, 'h1234, 0));
    tbl.push_back(mk(1, 0, 'hFFFF,  1, 8, 'hB,   0, 0, 8,  1, 1,  0, 5, 'h1234, 0));
    tbl.push_back(mk(1, 0, 'hFFFF,  1, 9, 'hC,   0, 0, 7,  1, 0,  0, 5, 'h1234, 0));
    tbl.push_back(mk(1, 0, 'hFFFF,  0, 0, 'h0,   0, 0, 7,  1, 0,  0, 5, 'h1234, 0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 7,  1, 0,  1, 7, 'hA,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 7,  1, 1,  1, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 8,  1, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 7,  0, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     1, 0, 'h5,   0, 0, 8,  0, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 0,  0, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 0,  0, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   1, 9, 9,  0, 1,  0, 8, 'hB,    0));
    tbl.push_back(mk(1, 9, 'h99,    0, 0, 'h0,   0, 0, 9,  1, 1,  1, 9, 'h99,   0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   1, 9, 9,  1, 1,  0, 9, 'h99,   0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 9,  1, 1,  0, 9, 'h99,   0));
    tbl.push_back(mk(1, 9, 'h77,    0, 0, 'h0,   0, 0, 9,  1, 1,  1, 9, 'h77,   0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 9,  1, 1,  0, 9, 'h77,   0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 9,  0, 1,  0, 9, 'h77,   0));
    tbl.push_back(mk(1, 3, 'h33,    0, 0, 'h0,   0, 0, 3,  0, 1,  1, 3, 'h33,   0));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 3,  0, 1,  0, 3, 'h33,   1));
    tbl.push_back(mk(0, 0, 'h0,     0, 0, 'h0,   0, 0, 0,  0, 1,  0, 3, 'h33,   1));

    foreach (tbl[i]) begin
      alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
      mem_valid = tbl[i].mv; mem_reg = tbl[i].mr; mem_data = tbl[i].md;
      issue_valid = tbl[i].iv; issue_reg = tbl[i].ir;
      q0_reg = tbl[i].q0; q1_reg = '0;
      @(negedge clk);
      chk($sformatf("t%0d.q0_busy", i), q0_busy, tbl[i].e_q0b);
      chk($sformatf("t%0d.q1_busy_x0", i), q1_busy, 1'b0);
      chk($sformatf("t%0d.mem_ready", i), mem_ready, tbl[i].e_rdy);
      @(posedge clk);
      #1;
      chk($sformatf("t%0d.write_enable", i), write_enable, tbl[i].e_we);
      chk($sformatf("t%0d.write_reg", i), write_reg, tbl[i].e_wr);
      chk($sformatf("t%0d.write", i), write, tbl[i].e_w);
      chk($sformatf("t%0d.stray_write", i), stray_write, tbl[i].e_stray);
    end

    // Sticky stray flag is cleared only by reset.
    do_reset();
    chk("stray_after_reset", stray_write, 1'b0);

    // Reset mid-cycle with two loads buffered and x4 pending.
    idle_inputs(); issue_valid = 1; issue_reg = 6;
    cycle("mr0");
    idle_inputs(); issue_valid = 1; issue_reg = 4; alu_valid = 1; alu_reg = 6; alu_data = 'h66;
    cycle("mr1");
    idle_inputs(); alu_valid = 1; mem_valid = 1; mem_reg = 11; mem_data = 'h11; q0_reg = 4;
    cycle("mr2");
    idle_inputs(); alu_valid = 1; mem_valid = 1; mem_reg = 12; mem_data = 'h12; q0_reg = 4;
    cycle("mr3");
    chk("mr.buffered", mem_ready, 1'b0);
    idle_inputs(); alu_valid = 1; q0_reg = 4;
    #3 res_n = 1'b0;
    #1;
    chk("mr.write_enable", write_enable, 1'b0);
    chk("mr.write", write, '0);
    chk("mr.write_reg", write_reg, '0);
    chk("mr.q0_busy_x4", q0_busy, 1'b0);
    chk("mr.mem_ready", mem_ready, 1'b1);
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    res_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    q0_reg = 4;
    for (int k = 0; k < 5; k++) cycle($sformatf("mr_post%0d", k));
    chk("mr.x4_idle", q0_busy, 1'b0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      alu_valid   = ($urandom_range(0, 9) < 4);
      alu_reg     = regnum'($urandom_range(0, 7));
      alu_data    = $urandom;
      mem_valid   = ($urandom_range(0, 1) == 1);
      mem_reg     = regnum'($urandom_range(0, 7));
      mem_data    = $urandom;
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_reg   = regnum'($urandom_range(0, 7));
      q0_reg      = regnum'($urandom_range(0, 7));
      q1_reg      = regnum'($urandom_range(0, 7));
      cycle($sformatf("r%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
